// File: rtl/cell_test_pkg.sv
// Shared types and truth-table constants for the 4-input cell stimulus checker.
package cell_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } state_t;

  // Truth tables indexed by {A1,A2,A3,A4}
  localparam logic [15:0] NAND4_TT = 16'h7FFF;
  localparam logic [15:0] AND4_TT  = 16'h8000;
  localparam logic [15:0] OR4_TT   = 16'hFFFE;
  localparam logic [15:0] NOR4_TT  = 16'h0001;

  localparam logic [3:0] VEC_LAST = 4'hF;
  localparam logic [4:0] ERR_MAX  = 5'd16;

endpackage

// File: rtl/settle_timer.sv
// Counts settle cycles for one stimulus vector; expired flags the last hold cycle.
module settle_timer #(
  parameter int unsigned SETTLE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(SETTLE - 1));

endmodule

// File: rtl/cell4_stim_check.sv
// Exhaustive stimulus generator and checker for a 4-input combinational cell.
module cell4_stim_check
  import cell_test_pkg::*;
#(
  parameter int unsigned SETTLE = 10,
  parameter logic [15:0] EXPECT = NAND4_TT
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FAIL_VEC,
  output logic       FAIL_VALID
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic       tmr_load;
  logic       tmr_en;
  logic       tmr_expired;
  logic       mismatch;
  logic [4:0] err_nxt;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (CK),
    .rst     (RST),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = APPLY;
          tmr_load  = 1'b1;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        tmr_load  = 1'b1;
        state_nxt = (vec == VEC_LAST) ? FINISH : APPLY;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Case inequality so an unknown or floating ZN is reported, never silently matched
  assign mismatch = (state == SAMPLE) && (ZN !== EXPECT[vec]);
  assign err_nxt  = (mismatch && (ERR_CNT != ERR_MAX)) ? ERR_CNT + 5'd1 : ERR_CNT;

  always_ff @(posedge CK) begin
    if (RST) begin
      state      <= IDLE;
      vec        <= '0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VEC   <= '0;
      FAIL_VALID <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (START) begin
            vec        <= '0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VEC   <= '0;
            FAIL_VALID <= 1'b0;
          end
        end
        SAMPLE: begin
          ERR_CNT <= err_nxt;
          if (mismatch && !FAIL_VALID) begin
            FAIL_VEC   <= vec;
            FAIL_VALID <= 1'b1;
          end
          // PASS is settled on the final sample so it is already valid while DONE is high
          if (vec != VEC_LAST) vec <= vec + 4'd1;
          else                 PASS <= (err_nxt == 5'd0);
        end
        FINISH:  vec <= '0;
        default: ;
      endcase
    end
  end

  assign {A1, A2, A3, A4} = (state == APPLY || state == SAMPLE) ? vec : 4'b0000;
  assign BUSY             = (state != IDLE);
  assign DONE             = (state == FINISH);

endmodule

// File: tb/tb_cell4_stim_check.sv
// Self-checking bench: table of cell models with expected run results, scoreboard of pending runs.
module tb_cell4_stim_check;

  localparam int SETTLE  = 10;
  localparam int RUN_LEN = 16 * (SETTLE + 1);

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [3:0] fvec;
    logic       fvalid;
  } exp_t;

  typedef struct {
    string name;
    int    mode;
    exp_t  exp;
  } row_t;

  logic       CK;
  logic       RST;
  logic       START;
  logic       ZN;
  logic       A1, A2, A3, A4;
  logic       BUSY, DONE, PASS, FAIL_VALID;
  logic [4:0] ERR_CNT;
  logic [3:0] FAIL_VEC;
  logic [3:0] a_vec;

  int   zn_mode;
  int   checks;
  int   errors;
  exp_t sb[$];
  row_t tbl[5];

  cell4_stim_check #(
    .SETTLE (SETTLE),
    .EXPECT (16'h7FFF)
  ) dut (
    .CK         (CK),
    .RST        (RST),
    .START      (START),
    .ZN         (ZN),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .A4         (A4),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PASS       (PASS),
    .ERR_CNT    (ERR_CNT),
    .FAIL_VEC   (FAIL_VEC),
    .FAIL_VALID (FAIL_VALID)
  );

  assign a_vec = {A1, A2, A3, A4};

  // Cell models: 0 NAND4, 1 stuck-at-1, 2 stuck-at-0, 3 unknown, 4 AND4
  function automatic logic model_zn(input int mode, input logic [3:0] v);
    case (mode)
      0:       return ~&v;
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return 1'bx;
      4:       return &v;
      default: return 1'b0;
    endcase
  endfunction

  always_comb ZN = model_zn(zn_mode, a_vec);

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},   BUSY,       0);
    check({tag, "_done"},   DONE,       0);
    check({tag, "_a"},      a_vec,      0);
    check({tag, "_pass"},   PASS,       0);
    check({tag, "_err"},    ERR_CNT,    0);
    check({tag, "_fvec"},   FAIL_VEC,   0);
    check({tag, "_fvalid"}, FAIL_VALID, 0);
  endtask

  task automatic start_run();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_busy", BUSY, 1);
    check("start_vec0", a_vec, 0);
  endtask

  // Follows a run from the accept edge; START can be pulsed or held during it.
  task automatic follow_run(input int pulse_at, input int hold_from);
    int   n;
    int   bad;
    bit   seen_done;
    exp_t e;
    n         = 0;
    bad       = 0;
    seen_done = 1'b0;
    while (!seen_done && n < RUN_LEN + 50) begin
      START = (n == pulse_at) || (hold_from >= 0 && n >= hold_from);
      tick();
      n++;
      if (DONE) seen_done = 1'b1;
      else if (a_vec !== 4'(n / (SETTLE + 1))) bad++;
    end
    check("done_latency", n, RUN_LEN);
    check("vec_sequence_bad_cycles", bad, 0);
    check("finish_vec_zero", a_vec, 0);
    tick();
    check("done_one_cycle", DONE, 0);
    check("idle_after_finish", BUSY, 0);
    if (seen_done && sb.size() > 0) begin
      e = sb.pop_front();
      check("res_pass",   PASS,       e.pass);
      check("res_err",    ERR_CNT,    e.err);
      check("res_fvec",   FAIL_VEC,   e.fvec);
      check("res_fvalid", FAIL_VALID, e.fvalid);
    end else begin
      check("scoreboard_pop", 0, 1);
    end
  endtask

  initial begin
    logic [15:0] tt;
    exp_t        xe;
    int          cnt;

    // Expected results for each cell model against the NAND4 truth table
    tbl[0] = '{"nand4",   0, '{1'b1, 5'd0,  4'b0000, 1'b0}};
    tbl[1] = '{"stuck1",  1, '{1'b0, 5'd1,  4'b1111, 1'b1}};
    tbl[2] = '{"stuck0",  2, '{1'b0, 5'd15, 4'b0000, 1'b1}};
    tbl[4] = '{"and4",    4, '{1'b0, 5'd16, 4'b0000, 1'b1}};
    // Unknown ZN: on a four-state simulator every vector mismatches; where X
    // collapses to a constant, the expectation follows the value ZN carries.
    tt = 16'h7FFF;
    xe = '{1'b0, 5'd0, 4'b0000, 1'b0};
    for (int v = 0; v < 16; v++) begin
      if (model_zn(3, 4'(v)) !== tt[v]) begin
        if (!xe.fvalid) xe.fvec = 4'(v);
        xe.fvalid = 1'b1;
        if (xe.err != 5'd16) xe.err = xe.err + 5'd1;
      end
    end
    xe.pass = (xe.err == 5'd0);
    tbl[3] = '{"unknown", 3, xe};

    checks  = 0;
    errors  = 0;
    zn_mode = 0;
    START   = 1'b0;
    RST     = 1'b1;
    tick();
    tick();
    check_cleared("reset");
    RST = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      zn_mode = tbl[i].mode;
      sb.push_back(tbl[i].exp);
      start_run();
      follow_run(-1, -1);
      repeat (5) tick();
      check({tbl[i].name, "_hold_err"},  ERR_CNT, tbl[i].exp.err);
      check({tbl[i].name, "_hold_pass"}, PASS,    tbl[i].exp.pass);
    end

    // Reset in the middle of vector 5 aborts the run
    zn_mode = 2;
    start_run();
    repeat (56) tick();
    check("pre_rst_vec", a_vec, 5);
    check("pre_rst_err", ERR_CNT, 5);
    RST = 1'b1;
    tick();
    check_cleared("midrun_rst");
    RST = 1'b0;
    cnt = 0;
    for (int c = 0; c < RUN_LEN + 20; c++) begin
      tick();
      if (DONE) cnt++;
    end
    check("no_done_after_abort", cnt, 0);
    RST   = 1'b1;
    START = 1'b1;
    tick();
    check("rst_over_start_busy", BUSY, 0);
    RST   = 1'b0;
    START = 1'b0;
    tick();
    zn_mode = 0;
    sb.push_back(tbl[0].exp);
    start_run();
    follow_run(-1, -1);

    // START pulsed mid-run, then held through DONE into a back-to-back run
    zn_mode = 2;
    sb.push_back(tbl[2].exp);
    start_run();
    follow_run(50, 100);
    tick();
    START = 1'b0;
    check("restart_busy", BUSY, 1);
    check("restart_err_cleared", ERR_CNT, 0);
    check("restart_fvalid_cleared", FAIL_VALID, 0);
    check("restart_fvec_cleared", FAIL_VEC, 0);
    check("restart_pass_cleared", PASS, 0);
    zn_mode = 0;
    sb.push_back(tbl[0].exp);
    follow_run(-1, -1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
